// File: rtl/arm_pkg.sv
// Shared definitions for the execute/writeback boundary:
// ALU opcodes, condition codes, flag indices, op-class helpers.
package arm_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    typedef enum logic [3:0] {
        CC_EQ, CC_NE, CC_CS, CC_CC,
        CC_MI, CC_PL, CC_VS, CC_VC,
        CC_HI, CC_LS, CC_GE, CC_LT,
        CC_GT, CC_LE, CC_AL, CC_NV
    } cond_e;

    localparam int NEG = 3;
    localparam int ZER = 2;
    localparam int CAR = 1;
    localparam int OVR = 0;

    // TST, TEQ, CMP, CMN occupy 8..B
    function automatic logic is_compare_op(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

    // Logical ops take C from the shifter and leave V alone
    function automatic logic is_logical_op(input logic [3:0] op);
        return (op[3:1] == 3'b000) ||
               (op[3:1] == 3'b100) ||
               (op[3:2] == 2'b11);
    endfunction

endpackage

// File: rtl/cond_check.sv
// Condition-field evaluator against an NZCV flag vector.
// Purely combinational; NV always fails.
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[NEG];
    assign z = flags[ZER];
    assign c = flags[CAR];
    assign v = flags[OVR];

    // Decode the condition field into a pass/fail bit
    always_comb begin
        pass = 1'b0;
        unique case (cond_e'(cond))
            CC_EQ: pass = z;
            CC_NE: pass = ~z;
            CC_CS: pass = c;
            CC_CC: pass = ~c;
            CC_MI: pass = n;
            CC_PL: pass = ~n;
            CC_VS: pass = v;
            CC_VC: pass = ~v;
            CC_HI: pass = c & ~z;
            CC_LS: pass = ~c | z;
            CC_GE: pass = (n == v);
            CC_LT: pass = (n != v);
            CC_GT: pass = ~z & (n == v);
            CC_LE: pass = z | (n != v);
            CC_AL: pass = 1'b1;
            CC_NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute/writeback boundary: NZCV register, condition gating,
// writeback pipeline register and skipped-instruction counter.
module cond_unit
    import arm_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic [3:0]  cond,
    input  logic        s_bit,
    input  logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags,
    input  logic        shift_carry,
    input  logic [3:0]  rd,
    input  logic        reg_write_req,
    input  logic        mem_write_req,
    input  logic        pc_write_req,
    output logic        cond_ex,
    output logic [3:0]  flags_q,
    output logic        carry_out,
    output logic        wb_valid,
    output logic [31:0] wb_result,
    output logic [3:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        wb_mem_write,
    output logic        wb_pc_write,
    output logic [15:0] skip_count
);

    logic        go;
    logic        commit;
    logic        cmp_op;
    logic        flag_we;
    logic [3:0]  flags_d;
    logic        wb_valid_q;
    logic [31:0] wb_result_q;
    logic [3:0]  wb_rd_q;
    logic        wb_reg_write_q;
    logic        wb_mem_write_q;
    logic        wb_pc_write_q;
    logic [15:0] skip_count_q;

    cond_check u_cond_check (
        .cond  (cond),
        .flags (flags_q),
        .pass  (cond_ex)
    );

    assign go      = ex_valid & ~stall & ~flush;
    assign commit  = go & cond_ex;
    assign cmp_op  = is_compare_op(alu_op);
    assign flag_we = commit & (s_bit | cmp_op);

    // Next flags: N/Z from ALU, C/V source depends on op class
    always_comb begin
        flags_d = flags_q;
        if (flag_we) begin
            flags_d[NEG] = alu_flags[NEG];
            flags_d[ZER] = alu_flags[ZER];
            if (is_logical_op(alu_op)) begin
                flags_d[CAR] = shift_carry;
            end else begin
                flags_d[CAR] = alu_flags[CAR];
                flags_d[OVR] = alu_flags[OVR];
            end
        end
    end

    // Architectural flag register
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= RESET_FLAGS;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Writeback register; bubbles clear enables but keep data
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q     <= 1'b0;
            wb_result_q    <= '0;
            wb_rd_q        <= '0;
            wb_reg_write_q <= 1'b0;
            wb_mem_write_q <= 1'b0;
            wb_pc_write_q  <= 1'b0;
        end else if (commit) begin
            wb_valid_q     <= 1'b1;
            wb_result_q    <= alu_result;
            wb_rd_q        <= rd;
            wb_reg_write_q <= reg_write_req & ~cmp_op;
            wb_mem_write_q <= mem_write_req;
            wb_pc_write_q  <= pc_write_req;
        end else begin
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_mem_write_q <= 1'b0;
            wb_pc_write_q  <= 1'b0;
        end
    end

    // Saturating count of condition-failed instructions
    always_ff @(posedge clk) begin
        if (reset) begin
            skip_count_q <= '0;
        end else if (go && !cond_ex && skip_count_q != 16'hFFFF) begin
            skip_count_q <= skip_count_q + 16'd1;
        end
    end

    assign carry_out    = flags_q[CAR];
    assign wb_valid     = wb_valid_q;
    assign wb_result    = wb_result_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_mem_write = wb_mem_write_q;
    assign wb_pc_write  = wb_pc_write_q;
    assign skip_count   = skip_count_q;

endmodule

// File: tb/tb_cond_unit.sv
// Randomized and directed bench for cond_unit against a
// behavioural model of flags, writeback and skip counting.
module tb_cond_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, stall, flush;
    logic [3:0]  cond;
    logic        s_bit;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        shift_carry;
    logic [3:0]  rd;
    logic        reg_write_req, mem_write_req, pc_write_req;
    logic        cond_ex;
    logic [3:0]  flags_q;
    logic        carry_out;
    logic        wb_valid;
    logic [31:0] wb_result;
    logic [3:0]  wb_rd;
    logic        wb_reg_write, wb_mem_write, wb_pc_write;
    logic [15:0] skip_count;

    always #5 clk = ~clk;

    cond_unit #(.RESET_FLAGS(4'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .stall         (stall),
        .flush         (flush),
        .cond          (cond),
        .s_bit         (s_bit),
        .alu_op        (alu_op),
        .alu_result    (alu_result),
        .alu_flags     (alu_flags),
        .shift_carry   (shift_carry),
        .rd            (rd),
        .reg_write_req (reg_write_req),
        .mem_write_req (mem_write_req),
        .pc_write_req  (pc_write_req),
        .cond_ex       (cond_ex),
        .flags_q       (flags_q),
        .carry_out     (carry_out),
        .wb_valid      (wb_valid),
        .wb_result     (wb_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_write  (wb_mem_write),
        .wb_pc_write   (wb_pc_write),
        .skip_count    (skip_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference state
    bit          mN, mZ, mC, mV;
    int          m_skips;
    bit          m_wv, m_wr, m_wm, m_wp;
    logic [31:0] m_res;
    logic [3:0]  m_rd;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic bit holds(input int c);
        bit ge;
        ge = (mN == mV);
        case (c)
            0:  return mZ;
            1:  return !mZ;
            2:  return mC;
            3:  return !mC;
            4:  return mN;
            5:  return !mN;
            6:  return mV;
            7:  return !mV;
            8:  return mC && !mZ;
            9:  return !mC || mZ;
            10: return ge;
            11: return !ge;
            12: return !mZ && ge;
            13: return mZ || !ge;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        {mN, mZ, mC, mV} = 4'h0;
        m_skips = 0;
        {m_wv, m_wr, m_wm, m_wp} = 4'h0;
        m_res = '0;
        m_rd = '0;
    endtask

    task automatic model_clock();
        int op;
        bit is_cmp, arith;
        if (reset) begin
            model_reset();
        end else begin
            op = int'(alu_op);
            is_cmp = (op >= 8 && op <= 11);
            arith = (op >= 2 && op <= 7) || op == 10 || op == 11;
            {m_wv, m_wr, m_wm, m_wp} = 4'h0;
            if (ex_valid && !stall && !flush) begin
                if (holds(int'(cond))) begin
                    if (s_bit || is_cmp) begin
                        mN = alu_flags[3];
                        mZ = alu_flags[2];
                        if (arith) begin
                            mC = alu_flags[1];
                            mV = alu_flags[0];
                        end else begin
                            mC = shift_carry;
                        end
                    end
                    m_wv = 1'b1;
                    m_res = alu_result;
                    m_rd = rd;
                    m_wr = reg_write_req && !is_cmp;
                    m_wm = mem_write_req;
                    m_wp = pc_write_req;
                end else begin
                    m_skips++;
                end
            end
        end
    endtask

    task automatic check_all();
        int es;
        es = (m_skips > 65535) ? 65535 : m_skips;
        chk("flags", 32'(flags_q), 32'({mN, mZ, mC, mV}));
        chk("carry", 32'(carry_out), 32'(mC));
        chk("wb_valid", 32'(wb_valid), 32'(m_wv));
        chk("wb_result", wb_result, m_res);
        chk("wb_rd", 32'(wb_rd), 32'(m_rd));
        chk("wb_reg_write", 32'(wb_reg_write), 32'(m_wr));
        chk("wb_mem_write", 32'(wb_mem_write), 32'(m_wm));
        chk("wb_pc_write", 32'(wb_pc_write), 32'(m_wp));
        chk("skip_count", 32'(skip_count), 32'(es));
    endtask

    task automatic drive(input bit v, input bit st, input bit fl,
                         input logic [3:0] c, input bit s,
                         input logic [3:0] op, input logic [3:0] af,
                         input bit sc, input logic [31:0] res,
                         input logic [3:0] r, input bit rw,
                         input bit mw, input bit pw);
        ex_valid = v;
        stall = st;
        flush = fl;
        cond = c;
        s_bit = s;
        alu_op = op;
        alu_flags = af;
        shift_carry = sc;
        alu_result = res;
        rd = r;
        reg_write_req = rw;
        mem_write_req = mw;
        pc_write_req = pw;
    endtask

    // Inputs are applied right after a falling edge
    task automatic step();
        #1;
        if (!reset) chk("cond_ex", 32'(cond_ex), 32'(holds(int'(cond))));
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_all();
    endtask

    int base;

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 0, 32'h0, 4'h0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        model_reset();
        @(negedge clk);
        check_all();
        chk("rst_flags", 32'(flags_q), 32'h0);
        chk("rst_wb_valid", 32'(wb_valid), 32'h0);
        chk("rst_skip", 32'(skip_count), 32'h0);
        reset = 1'b0;

        // AL ADDS
        drive(1, 0, 0, 4'hE, 1, 4'h4, 4'b0110, 0, 32'h1234, 4'h3, 1, 0, 0);
        step();
        chk("t1_flags", 32'(flags_q), 32'h6);
        chk("t1_carry", 32'(carry_out), 32'h1);
        chk("t1_wb_valid", 32'(wb_valid), 32'h1);
        chk("t1_reg_write", 32'(wb_reg_write), 32'h1);

        // CMP then BEQ
        drive(1, 0, 0, 4'hE, 0, 4'hA, 4'b0110, 0, 32'h55, 4'h2, 1, 0, 0);
        step();
        chk("t2_cmp_rw", 32'(wb_reg_write), 32'h0);
        chk("t2_cmp_z", 32'(flags_q[2]), 32'h1);
        drive(1, 0, 0, 4'h0, 0, 4'h4, 4'h0, 0, 32'h80, 4'hF, 0, 0, 1);
        #1 chk("t2_beq_cond", 32'(cond_ex), 32'h1);
        step();
        chk("t2_beq_pc", 32'(wb_pc_write), 32'h1);

        // Set 0001 then logical MOVS keeps V
        drive(1, 0, 0, 4'hE, 1, 4'h4, 4'b0001, 0, 32'h0, 4'h1, 1, 0, 0);
        step();
        chk("t3_pre", 32'(flags_q), 32'h1);
        drive(1, 0, 0, 4'hE, 1, 4'hD, 4'b1000, 1, 32'h9, 4'h1, 1, 0, 0);
        step();
        chk("t3_movs", 32'(flags_q), 32'hB);

        // Z=0: three failing EQ, then a stalled EQ
        base = m_skips;
        repeat (3) begin
            drive(1, 0, 0, 4'h0, 1, 4'h4, 4'b0100, 0, 32'h7, 4'h4, 1, 1, 1);
            step();
            chk("t4_wb_valid", 32'(wb_valid), 32'h0);
        end
        drive(1, 1, 0, 4'h0, 1, 4'h4, 4'b0100, 0, 32'h7, 4'h4, 1, 1, 1);
        step();
        chk("t4_skip", 32'(skip_count), 32'(base + 3));
        chk("t4_flags", 32'(flags_q), 32'hB);

        // Stall and flush together on AL ADDS
        drive(1, 1, 1, 4'hE, 1, 4'h4, 4'b1111, 1, 32'hAA, 4'h6, 1, 1, 1);
        step();
        chk("t5_flags", 32'(flags_q), 32'hB);
        chk("t5_wb_valid", 32'(wb_valid), 32'h0);
        chk("t5_skip", 32'(skip_count), 32'(base + 3));

        // Reset during a committing instruction
        reset = 1'b1;
        drive(1, 0, 0, 4'hE, 1, 4'h4, 4'b1111, 1, 32'hBEEF, 4'h7, 1, 1, 1);
        step();
        chk("t6_flags", 32'(flags_q), 32'h0);
        chk("t6_wb_valid", 32'(wb_valid), 32'h0);
        chk("t6_result", wb_result, 32'h0);
        chk("t6_skip", 32'(skip_count), 32'h0);
        reset = 1'b0;

        // Randomized stream
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 9) < 8,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0,
                  4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)),
                  $urandom,
                  4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            step();
        end
        reset = 1'b0;

        // Drive skip_count into saturation with NV S instructions
        drive(1, 0, 0, 4'hF, 1, 4'h4, 4'b1111, 1, 32'h1, 4'h1, 1, 1, 1);
        repeat (65540) begin
            @(posedge clk);
            model_clock();
        end
        @(negedge clk);
        check_all();
        chk("sat", 32'(skip_count), 32'hFFFF);
        step();
        chk("sat_hold", 32'(skip_count), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
# cond_unit

Execute/writeback boundary stage placed directly downstream of the ALU. It holds the architectural NZCV flag register and evaluates each instruction's 4-bit condition field against it. It gates register, memory and PC write enables and updates flags according to the S-bit and op class. It registers the ALU result into the writeback pipeline register and returns the stored carry to the ALU `carry` input.

## Interface
- `RESET_FLAGS`, 4'h0: NZCV value loaded on reset.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `ex_valid`  in  1  execute stage holds a real instruction.
- `stall`  in  1  execute stage frozen this cycle.
- `flush`  in  1  kill the instruction in execute.
- `cond`  in  4  instruction condition field.
- `s_bit`  in  1  instruction requests a flag update.
- `alu_op`  in  4  opcode presented to the ALU.
- `alu_result`  in  32  ALU result `c`.
- `alu_flags`  in  4  ALU flags, bit3 N, bit2 Z, bit1 C, bit0 V.
- `shift_carry`  in  1  shifter carry-out, used as C for logical ops.
- `rd`  in  4  destination register.
- `reg_write_req`, `mem_write_req`, `pc_write_req`  in  1 each  decoder write requests.
- `cond_ex`  out  1  combinational: condition passes on current `flags_q`.
- `flags_q`  out  4  registered NZCV.
- `carry_out`  out  1  `flags_q[1]`, wired to the ALU `carry` input.
- `wb_valid`  out  1  WB register holds a committed instruction.
- `wb_result`  out  32  registered ALU result.
- `wb_rd`  out  4  registered destination.
- `wb_reg_write`, `wb_mem_write`, `wb_pc_write`  out  1 each  gated, registered enables.
- `skip_count`  out  16  saturating count of condition-failed instructions.

## Operation
- `go = ex_valid & ~stall & ~flush`.
- `commit = go & cond_ex`.
- Condition evaluation uses `flags_q`:
  - 0 EQ Z, 1 NE ~Z, 2 CS C, 3 CC ~C, 4 MI N, 5 PL ~N, 6 VS V, 7 VC ~V.
  - 8 HI C&~Z, 9 LS ~C|Z, A GE N==V, B LT N!=V, C GT ~Z&(N==V), D LE Z|(N!=V).
  - E AL 1; F evaluates to 0 (never).
- Compare ops are 8–B (TST, TEQ, CMP, CMN).
- Arithmetic ops are 2–7, A, B; logical ops are 0, 1, 8, 9, C–F.
- Flag write occurs when `commit & (s_bit | compare op)`:
  - N and Z always take `alu_flags[3:2]`.
  - Arithmetic ops: C and V take `alu_flags[1:0]`.
  - Logical ops: C takes `shift_carry`; V is unchanged.
- Otherwise `flags_q` holds.
- WB register on `commit`:
  - `wb_valid`=1.
  - `wb_result`=`alu_result`, `wb_rd`=`rd`.
  - `wb_reg_write` = `reg_write_req & ~compare op`.
  - `wb_mem_write` = `mem_write_req`; `wb_pc_write` = `pc_write_req`.
- WB register when not committing (bubble):
  - `wb_valid` and all three enables = 0.
  - `wb_result` and `wb_rd` hold.
- `skip_count` increments when `go & ~cond_ex`; it saturates at 16'hFFFF.

## Timing
- Reset values: `flags_q`=`RESET_FLAGS`, `carry_out`=`RESET_FLAGS[1]`, `wb_valid`=0, all `wb_*` enables 0, `wb_result`=0, `wb_rd`=0, `skip_count`=0.
- `cond_ex` is combinational, valid in the same cycle as `cond`.
- Flag update latency is 1 cycle: an S instruction at cycle t changes `flags_q` at t+1. A dependent conditional instruction at t+1 sees the new flags; there is no same-cycle forwarding.
- WB outputs appear 1 cycle after the instruction's commit cycle.
- `flush` has priority over `stall`. Either one gives a bubble with no flag write and no `skip_count` increment.
- `ex_valid`=0 gives a bubble; `cond`, `s_bit` and `alu_*` are ignored.
- `reset` asserted mid-stream overrides all other inputs that cycle.
- Cond F with `s_bit`=1 changes no flags and counts as a skip.

## Structure
- Shared package `arm_pkg`:
  - ALU opcode constants 4'h0–4'hF.
  - Condition-code enum EQ..NV.
  - Flag index constants NEG=3, ZER=2, CAR=1, OVR=0.
  - Helper functions `is_compare_op` and `is_logical_op`.
- One combinational sub-module, `cond_check` (`cond`, `flags` → `pass`), instantiated once.

## Test plan
- Reset with `RESET_FLAGS`=4'h0, then AL ADD `s_bit`=1, `alu_flags`=4'b0110 → next cycle `flags_q`=4'b0110, `carry_out`=1, `wb_valid`=1, `wb_reg_write`=1.
- CMP (op A), `alu_flags`=4'b0110, `reg_write_req`=1, then BEQ (`cond`=0, `pc_write_req`=1) → CMP gives `wb_reg_write`=0 and `flags_q` Z=1; BEQ gives `cond_ex`=1 and `wb_pc_write`=1.
- `flags_q`=4'b0001, logical MOVS (op D, `s_bit`=1), `alu_flags`=4'b1000, `shift_carry`=1 → `flags_q`=4'b1011 (V kept).
- Z=0, then 3 valid EQ instructions, then 1 stalled EQ → `skip_count`=3, `wb_valid`=0 throughout, `flags_q` unchanged.
- `stall`=1 and `flush`=1 together on an AL ADDS → no flag change, bubble in WB, `skip_count` unchanged.
- `reset` asserted during a committing instruction → next cycle all outputs at reset values; preload `skip_count`=16'hFFFF, then one more skip → stays 16'hFFFF.
